// File: rtl/qspi_line_fetch_if.sv
// Fetch request/response and quad-SPI pin bundle for qspi_line_fetch.
// master = environment side (cache requester plus flash din); slave = the fetch engine.
`timescale 1ns/1ps
interface qspi_line_fetch_if #(
    parameter int unsigned LINE_SIZE = 16
);
    logic                   req;
    logic [23:0]            addr;
    logic                   busy;
    logic                   done;
    logic [LINE_SIZE*8-1:0] line;
    logic                   sck;
    logic                   ce_n;
    logic [3:0]             dout;
    logic [3:0]             douten;
    logic [3:0]             din;

    modport master (
        output req,
        output addr,
        output din,
        input  busy,
        input  done,
        input  line,
        input  sck,
        input  ce_n,
        input  dout,
        input  douten
    );

    modport slave (
        input  req,
        input  addr,
        input  din,
        output busy,
        output done,
        output line,
        output sck,
        output ce_n,
        output dout,
        output douten
    );
endinterface

// File: rtl/qspi_line_fetch.sv
// Cache line-fill engine: one Quad I/O Fast Read (EBh) per request, SCK = clk/2,
// line delivered with a one-cycle done strobe.
`timescale 1ns/1ps
module qspi_line_fetch #(
    parameter int unsigned LINE_SIZE    = 16,
    parameter int unsigned DUMMY_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    qspi_line_fetch_if.slave bus
);
    localparam int unsigned NibTotal = 2 * LINE_SIZE;
    localparam int unsigned CntMax   = (NibTotal > 8) ?
        ((NibTotal > DUMMY_CYCLES) ? NibTotal : DUMMY_CYCLES) :
        ((DUMMY_CYCLES > 8) ? DUMMY_CYCLES : 8);
    localparam int unsigned CntW     = $clog2(CntMax);
    localparam int unsigned LineW    = LINE_SIZE * 8;
    localparam logic [7:0]  CmdQuadRead = 8'hEB;

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StMode, StDummy, StData, StDone
    } state_e;

    state_e            state_q, state_d, state_nxt;
    logic              phase_q, phase_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [23:0]       addr_q, addr_d;
    logic [LineW-1:0]  line_q, line_d;
    logic [CntW-1:0]   nib_idx;
    logic [CntW+1:0]   nib_pos;
    logic [23:0]       addr_shift;
    logic [7:0]        cmd_byte;
    logic [3:0]        dout_c;
    logic [3:0]        douten_c;

    // Counter runs down from (SCK periods in state - 1) to 0.
    function automatic logic [CntW-1:0] reload(input state_e st);
        logic [CntW-1:0] r;
        r = '0;
        case (st)
            StCmd:   r = CntW'(7);
            StAddr:  r = CntW'(5);
            StMode:  r = CntW'(1);
            StDummy: r = CntW'(DUMMY_CYCLES - 1);
            StData:  r = CntW'(NibTotal - 1);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Nibble n lands in byte n/2, high half when n is even.
    assign nib_idx    = CntW'(NibTotal - 1) - cnt_q;
    assign nib_pos    = {nib_idx[CntW-1:1], ~nib_idx[0], 2'b00};
    assign addr_shift = addr_q >> {cnt_q, 2'b00};
    assign cmd_byte   = CmdQuadRead;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        line_d    = line_q;
        state_nxt = StIdle;
        case (state_q)
            StCmd:   state_nxt = StAddr;
            StAddr:  state_nxt = StMode;
            StMode:  state_nxt = StDummy;
            StDummy: state_nxt = StData;
            StData:  state_nxt = StDone;
            default: state_nxt = StIdle;
        endcase
        unique case (state_q)
            StIdle: begin
                phase_d = 1'b0;
                if (bus.req) begin
                    state_d = StCmd;
                    cnt_d   = reload(StCmd);
                    addr_d  = bus.addr & ~24'(LINE_SIZE - 1);
                end
            end
            StDone: state_d = StIdle;
            default: begin
                phase_d = ~phase_q;
                // End of phase 1: sample din and advance one SCK period.
                if (phase_q) begin
                    if (state_q == StData) begin
                        line_d[nib_pos +: 4] = bus.din;
                    end
                    if (cnt_q == '0) begin
                        state_d = state_nxt;
                        cnt_d   = reload(state_nxt);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        dout_c   = 4'h0;
        douten_c = 4'h0;
        case (state_q)
            StCmd: begin
                dout_c   = {3'b000, cmd_byte[cnt_q[2:0]]};
                douten_c = 4'b0001;
            end
            StAddr: begin
                dout_c   = addr_shift[3:0];
                douten_c = 4'hF;
            end
            StMode: begin
                dout_c   = 4'h0;
                douten_c = 4'hF;
            end
            default: ;
        endcase
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone);
    assign bus.ce_n   = (state_q == StIdle) || (state_q == StDone);
    assign bus.sck    = phase_q;
    assign bus.dout   = dout_c;
    assign bus.douten = douten_c;
    assign bus.line   = line_q;
endmodule
